// File: rtl/serdes_arb_pkg.sv
// Shared types, TileLink opcode constants and beat-count helpers for the serial-link flit arbiter.
package serdes_arb_pkg;

  localparam int NUM_CH       = 5;
  localparam int BEAT_BYTES   = 8;
  localparam int MAX_LOG_SIZE = 6;
  localparam int BEAT_LOG     = $clog2(BEAT_BYTES);
  localparam int CNT_W        = MAX_LOG_SIZE - BEAT_LOG;

  typedef enum logic [2:0] {
    CH_A = 3'd0,
    CH_B = 3'd1,
    CH_C = 3'd2,
    CH_D = 3'd3,
    CH_E = 3'd4
  } chan_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [2:0] OP_A_PUT_FULL       = 3'd0;
  localparam logic [2:0] OP_A_LOGICAL        = 3'd3;
  localparam logic [2:0] OP_C_ACCESS_ACK_DAT = 3'd1;
  localparam logic [2:0] OP_C_PROBE_ACK_DAT  = 3'd5;
  localparam logic [2:0] OP_C_RELEASE_DATA   = 3'd7;
  localparam logic [2:0] OP_D_ACCESS_ACK_DAT = 3'd1;
  localparam logic [2:0] OP_D_GRANT_DATA     = 3'd5;

  function automatic logic has_data(input logic [2:0] chan, input logic [2:0] opcode);
    logic hd;
    hd = 1'b0;
    case (chan)
      CH_A, CH_B: hd = (opcode >= OP_A_PUT_FULL) && (opcode <= OP_A_LOGICAL);
      CH_C:       hd = (opcode == OP_C_ACCESS_ACK_DAT) || (opcode == OP_C_PROBE_ACK_DAT) ||
                       (opcode == OP_C_RELEASE_DATA);
      CH_D:       hd = (opcode == OP_D_ACCESS_ACK_DAT) || (opcode == OP_D_GRANT_DATA);
      default:    hd = 1'b0;
    endcase
    return hd;
  endfunction

  // Oversized messages saturate at the largest burst rather than wrapping the counter.
  function automatic logic [CNT_W:0] num_beats(input logic hd, input logic [3:0] size);
    logic [CNT_W:0] b;
    b = (CNT_W+1)'(1);
    if (hd && (size > 4'(BEAT_LOG))) begin
      if (size > 4'(MAX_LOG_SIZE)) b = (CNT_W+1)'(1) << CNT_W;
      else                         b = (CNT_W+1)'(1) << (size - 4'(BEAT_LOG));
    end
    return b;
  endfunction

endpackage

// File: rtl/serdes_rr_pick.sv
// Combinational round-robin picker: first requester at or after prio, wrapping modulo NUM_CH.
module serdes_rr_pick
  import serdes_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        prio,
  output logic [2:0]        gnt_idx,
  output logic              any
);

  logic [3:0] w_idx;
  logic       w_found;

  always_comb begin
    gnt_idx = 3'd0;
    w_found = 1'b0;
    w_idx   = 4'd0;
    any     = |req;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, prio} + 4'(k);
      if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
      if (!w_found && req[w_idx[2:0]]) begin
        w_found = 1'b1;
        gnt_idx = w_idx[2:0];
      end
    end
  end

endmodule

// File: rtl/serdes_flit_arbiter.sv
// Round-robin arbiter with message locking that merges the five TileLink channels onto one link.
// Optional simulation checks are enabled by defining SERDES_FLIT_ARBITER_ASSERT_EN.
module serdes_flit_arbiter
  import serdes_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    in_valid,
  output logic [NUM_CH-1:0]    in_ready,
  input  logic [NUM_CH*3-1:0]  in_opcode,
  input  logic [NUM_CH*3-1:0]  in_param,
  input  logic [NUM_CH*4-1:0]  in_size,
  input  logic [NUM_CH*4-1:0]  in_source,
  input  logic [NUM_CH*32-1:0] in_address,
  input  logic [NUM_CH*64-1:0] in_data,
  input  logic [NUM_CH-1:0]    in_corrupt,
  input  logic [NUM_CH*8-1:0]  in_union,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_chanId,
  output logic [2:0]           out_opcode,
  output logic [2:0]           out_param,
  output logic [3:0]           out_size,
  output logic [3:0]           out_source,
  output logic [31:0]          out_address,
  output logic [63:0]          out_data,
  output logic                 out_corrupt,
  output logic [7:0]           out_union,
  output logic                 busy
);

  // Handshake: a flit transfers on out_valid & out_ready; once offered it stays stable until
  // it transfers, and only the granted channel sees in_ready, in that same cycle.
  state_e         r_state;
  logic [2:0]     r_grant;
  logic [2:0]     r_prio;
  logic [CNT_W:0] r_beats_left;

  logic [2:0]     w_pick_idx;
  logic           w_pick_any;
  logic [2:0]     w_grant;
  logic           w_sel_valid;
  logic           w_fire;
  logic [CNT_W:0] w_beats;
  logic [2:0]     w_next_prio;

  serdes_rr_pick u_pick (
    .req     (in_valid),
    .prio    (r_prio),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_grant = (r_state == ST_IDLE) ? w_pick_idx : r_grant;

  always_comb begin
    w_sel_valid = 1'b0;
    out_opcode  = '0;
    out_param   = '0;
    out_size    = '0;
    out_source  = '0;
    out_address = '0;
    out_data    = '0;
    out_corrupt = 1'b0;
    out_union   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == 3'(i)) begin
        w_sel_valid = in_valid[i];
        out_opcode  = in_opcode[3*i +: 3];
        out_param   = in_param[3*i +: 3];
        out_size    = in_size[4*i +: 4];
        out_source  = in_source[4*i +: 4];
        out_address = in_address[32*i +: 32];
        out_data    = in_data[64*i +: 64];
        out_corrupt = in_corrupt[i];
        out_union   = in_union[8*i +: 8];
      end
    end
  end

  assign out_valid   = (r_state == ST_IDLE) ? w_pick_any : w_sel_valid;
  assign out_chanId  = w_grant;
  assign busy        = (r_state == ST_BUSY);
  assign w_fire      = out_valid & out_ready;
  assign w_beats     = num_beats(has_data(w_grant, out_opcode), out_size);
  assign w_next_prio = (w_grant == 3'(NUM_CH-1)) ? 3'd0 : w_grant + 3'd1;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      in_ready[i] = !reset && out_ready && out_valid && (w_grant == 3'(i));
  end

  // A backpressured offer also locks, so the picker cannot swap the flit before it transfers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 3'd0;
      r_prio       <= 3'd0;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (out_valid) begin
            if (w_fire && (w_beats == (CNT_W+1)'(1))) begin
              r_prio <= w_next_prio;
            end else begin
              r_state      <= ST_BUSY;
              r_grant      <= w_grant;
              r_beats_left <= w_fire ? (w_beats - (CNT_W+1)'(1)) : w_beats;
            end
          end
        end
        ST_BUSY: begin
          if (w_fire) begin
            r_beats_left <= r_beats_left - (CNT_W+1)'(1);
            if (r_beats_left == (CNT_W+1)'(1)) begin
              r_state <= ST_IDLE;
              r_prio  <= w_next_prio;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERDES_FLIT_ARBITER_ASSERT_EN
  logic w_size_bad;
  always_comb begin
    w_size_bad = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_valid[i] && (in_size[4*i +: 4] > 4'(MAX_LOG_SIZE))) w_size_bad = 1'b1;
  end

  a_hold_stable: assert property (@(posedge clock) disable iff (reset)
    (r_state == ST_BUSY && out_valid && !out_ready) |=>
      (out_valid && $stable(out_chanId) && $stable(out_opcode) && $stable(out_param) &&
       $stable(out_size) && $stable(out_source) && $stable(out_address) &&
       $stable(out_data) && $stable(out_corrupt) && $stable(out_union)));
  a_size_legal: assert property (@(posedge clock) disable iff (reset) !w_size_bad);
  a_ready_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(in_ready));
  a_grant_range: assert property (@(posedge clock) disable iff (reset)
    !(w_fire && (w_grant >= 3'(NUM_CH))));
`endif

endmodule

// File: doc/serdes_flit_arbiter.md
Name:
serdes_flit_arbiter

Overview:
- Shares one outbound serial link's flit interface among the five TileLink channels (A, B, C, D, E).
- Sits upstream of the link serializer. Its flit fields mirror the deserializer output bundle: chanId, opcode, param, size, source, address, data, corrupt, union.
- Arbitration is round-robin with message-level locking, so multi-beat data messages are never interleaved on the link.

Parameters:
- NUM_CH, 5: number of channels; index i maps to chanId i (0=A, 1=B, 2=C, 3=D, 4=E).
- BEAT_BYTES, 8: bytes per data beat (64-bit data field).
- MAX_LOG_SIZE, 6: largest legal size field value, i.e. 64 B, which is 8 beats.
- CNT_W, 3: width of the beat counter; equals MAX_LOG_SIZE - log2(BEAT_BYTES).

Ports:
- clock, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, NUM_CH: per-channel valid.
- in_ready, output, NUM_CH: per-channel ready.
- in_opcode, input, NUM_CH*3: packed per channel, channel i at [3i+2:3i].
- in_param, input, NUM_CH*3: packed per channel.
- in_size, input, NUM_CH*4: packed per channel.
- in_source, input, NUM_CH*4: packed per channel.
- in_address, input, NUM_CH*32: packed per channel.
- in_data, input, NUM_CH*64: packed per channel.
- in_corrupt, input, NUM_CH: per-channel corrupt bit.
- in_union, input, NUM_CH*8: packed per channel.
- out_valid, output, 1: flit valid toward the serializer.
- out_ready, input, 1: serializer ready.
- out_chanId, output, 3: index of the granted channel.
- out_opcode, output, 3: granted channel's opcode.
- out_param, output, 3: granted channel's param.
- out_size, output, 4: granted channel's size.
- out_source, output, 4: granted channel's source.
- out_address, output, 32: granted channel's address.
- out_data, output, 64: granted channel's data.
- out_corrupt, output, 1: granted channel's corrupt bit.
- out_union, output, 8: granted channel's union field.
- busy, output, 1: high in BUSY state.

Behaviour:
- Fire conditions:
  - Output fire = out_valid & out_ready.
  - in_ready[i] = out_ready & (grant == i) & out_valid.
  - All other in_ready bits are 0.
- Output muxing:
  - out_* fields are a combinational mux of the granted channel; out_chanId = grant.
  - Zero-cycle latency: a flit passes through in its arrival cycle.
- hasData decode per channel:
  - A and B: opcode 0..3.
  - C: opcode 1, 5 or 7.
  - D: opcode 1 or 5.
  - E: never.
- Beat count:
  - hasData & size > 3: beats = 1 << (size - 3).
  - Otherwise: beats = 1.
- State machine: IDLE / BUSY. Registers are grant (3 b), beats_left (CNT_W+1 b) and prio pointer (3 b).
- IDLE:
  - grant = first i with in_valid[i], scanning from prio upward, modulo NUM_CH.
  - out_valid = |in_valid.
  - Fire with beats == 1: stay IDLE; prio <= grant + 1, wrapping 4 -> 0.
  - Fire with beats > 1: go BUSY; latch grant; beats_left <= beats - 1.
  - out_valid without fire: go BUSY; latch grant; beats_left <= beats. This keeps the offered flit stable and irrevocable.
- BUSY:
  - Grant is held; out_valid = in_valid[grant]. Other channels are ignored even if valid.
  - On fire: beats_left decrements.
  - Fire with beats_left == 1: go IDLE; prio <= grant + 1.
- Boundary cases:
  - Held channel drops valid mid-message: out_valid = 0 and the lock is kept. Only reset releases it.
  - Single-beat flit accepted in the same cycle it arrives: no state change other than prio.
  - All channels idle: out_valid = 0, busy = 0.
- Reset values:
  - state IDLE, prio 0, grant 0, beats_left 0.
  - out_valid follows the IDLE mux. During reset cycles in_ready = 0 (gated by reset).
  - Reset mid-burst drops the lock immediately.
- size > MAX_LOG_SIZE: beats is saturated at 2^CNT_W.

Optional Feature:
- Macro: SERDES_FLIT_ARBITER_ASSERT_EN.
- When defined, simulation assertions (disabled during reset) flag:
  - in BUSY, a held flit's valid dropping, or any field changing, while out_valid & !out_ready;
  - in_size above MAX_LOG_SIZE on a valid input;
  - more than one in_ready bit high;
  - fire while grant >= NUM_CH.
- When undefined, no assertion logic is emitted; functional behaviour is identical.

Decomposition:
- Package serdes_arb_pkg:
  - chan_e enum (CH_A..CH_E);
  - TileLink opcode constants;
  - function has_data(chan, opcode);
  - function num_beats(has_data, size);
  - localparams BEAT_BYTES and MAX_LOG_SIZE.
- Sub-module serdes_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_CH], prio.
  - Outputs: gnt_idx, any.

Test Plan:
1. Single-beat arbitration: in_valid = 5'b00101, prio 0, out_ready = 1. Expect chanId 0 in cycle 0 and chanId 2 in cycle 1, each for one cycle; prio ends at 3.
2. Burst lock:
   - Stimulus: A PutFull (opcode 0, size 6) and D valid together, out_ready = 1.
   - Expect 8 consecutive A beats with chanId 0, then D; busy = 1 for beats 2..8.
3. Backpressure hold:
   - Stimulus: C valid, out_ready = 0 for 3 cycles, B raises valid in cycle 1.
   - Expect grant to stay on C (chanId 2) with stable fields, then C fires; B follows.
4. Fairness: all five channels continuously valid, single-beat. Expect chanId sequence 0, 1, 2, 3, 4, 0 with no starvation.
5. Reset mid-burst:
   - Stimulus: reset asserted after beat 3 of an 8-beat D GrantData (opcode 5, size 6).
   - Expect state IDLE, prio 0, in_ready = 0 during reset; A is granted first afterwards.
6. Small data message: D AccessAckData, size 2. Expect beats = 1 and no BUSY entry when out_ready = 1.
